// File: rtl/sand_sweep_if.sv
// rtl/sand_sweep_if.sv - playfield RAM and sand core signal bundle for the sweep engine
//   master (sweeper): mem_req, mem_addr, mem_we, mem_wdata, upd_region, upd_floor,
//                     upd_screenbegin, upd_screenend out; mem_gnt, mem_rdata,
//                     upd_new_region, upd_new_floor in
//   slave  (RAM arbiter + sand core): the mirror image
interface sand_sweep_if #(
  parameter int ADDR_W = 15
);
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [31:0]       upd_region;
  logic [31:0]       upd_floor;
  logic              upd_screenbegin;
  logic              upd_screenend;
  logic [31:0]       upd_new_region;
  logic [31:0]       upd_new_floor;

  modport master (
    output mem_req, mem_addr, mem_we, mem_wdata,
    output upd_region, upd_floor, upd_screenbegin, upd_screenend,
    input  mem_gnt, mem_rdata, upd_new_region, upd_new_floor
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_wdata,
    input  upd_region, upd_floor, upd_screenbegin, upd_screenend,
    output mem_gnt, mem_rdata, upd_new_region, upd_new_floor
  );
endinterface

// File: rtl/sand_sweep.sv
// rtl/sand_sweep.sv - frame-rate scan engine feeding the sand_update core
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : frame strobe, honoured only while idle
//   busy, done   : sweep in progress / one-cycle completion pulse
//   bus          : RAM req/gnt port plus region/floor words to and from the core
module sand_sweep #(
  parameter int WORDS_PER_ROW = 40,
  parameter int ROWS          = 480,
  parameter int ADDR_W        = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  sand_sweep_if.master bus
);
  localparam int W_W   = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [W_W-1:0]    W_LAST     = W_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 2);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WORDS_PER_ROW);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_R, S_RD_F, S_CAP_F, S_WR_R, S_WR_F
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [W_W-1:0]     r_w;
  logic [ROW_W-1:0]   r_row;
  logic [ADDR_W-1:0]  r_base;
  logic [31:0]        r_region;
  logic [31:0]        r_floor;
  logic [31:0]        r_fbuf;
  logic               r_busy;
  logic               r_done;
  logic               r_reg_pend;
  logic [ADDR_W-1:0]  w_addr_r;
  logic [ADDR_W-1:0]  w_addr_f;
  logic               w_last_word;
  logic               w_last_row;

  // base walks in steps of one row, so no multiplier is needed
  assign w_addr_r    = r_base + ADDR_W'(r_w);
  assign w_addr_f    = w_addr_r + ROW_STRIDE;
  assign w_last_word = (r_w == W_LAST);
  // the row counter stops at ROWS-2: the bottom row is only ever a floor
  assign w_last_row  = (r_row == ROW_LAST);

  assign busy                = r_busy;
  assign done                = r_done;
  assign bus.upd_region      = r_region;
  assign bus.upd_floor       = r_floor;
  assign bus.upd_screenbegin = (r_w == '0);
  assign bus.upd_screenend   = w_last_word;

  always_comb begin
    w_next        = r_state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RD_R;
      end
      S_RD_R: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = w_addr_r;
        if (bus.mem_gnt) w_next = S_RD_F;
      end
      S_RD_F: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = w_addr_f;
        if (bus.mem_gnt) w_next = S_CAP_F;
      end
      S_CAP_F: begin
        w_next = S_WR_R;
      end
      S_WR_R: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w_addr_r;
        bus.mem_wdata = bus.upd_new_region;
        if (bus.mem_gnt) w_next = S_WR_F;
      end
      S_WR_F: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = w_addr_f;
        bus.mem_wdata = r_fbuf;
        if (bus.mem_gnt) w_next = (w_last_word && w_last_row) ? S_IDLE : S_RD_R;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_w        <= '0;
      r_row      <= '0;
      r_base     <= '0;
      r_region   <= '0;
      r_floor    <= '0;
      r_fbuf     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_reg_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_w    <= '0;
            r_row  <= '0;
            r_base <= '0;
          end
        end
        S_RD_R: begin
          if (bus.mem_gnt) r_reg_pend <= 1'b1;
        end
        S_RD_F: begin
          // read data is only valid on the first RD_F cycle; a stall must not resample it
          if (r_reg_pend) begin
            r_region   <= bus.mem_rdata;
            r_reg_pend <= 1'b0;
          end
        end
        S_CAP_F: begin
          r_floor <= bus.mem_rdata;
        end
        S_WR_R: begin
          // the region write changes nothing the core sees, but buffering keeps WR_F independent of it
          if (bus.mem_gnt) r_fbuf <= bus.upd_new_floor;
        end
        S_WR_F: begin
          if (bus.mem_gnt) begin
            if (!w_last_word) begin
              r_w <= r_w + 1'b1;
            end else if (!w_last_row) begin
              r_w    <= '0;
              r_row  <= r_row + 1'b1;
              r_base <= r_base + ROW_STRIDE;
            end else begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sand_sweep.sv
// tb/tb_sand_sweep.sv - self-checking bench for sand_sweep against a row/word loop model
module tb_sand_sweep;
  localparam int W      = 2;
  localparam int R      = 3;
  localparam int AW     = 15;
  localparam int NW     = W * R;
  localparam int NWORDS = (R - 1) * W;

  typedef struct {
    int          addr;
    bit          we;
    logic [31:0] wdata;
    bit          sb;
    bit          se;
    logic [31:0] region;
  } acc_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] ram     [NW];
  logic [31:0] img     [NW];
  logic [31:0] exp_ram [NW];
  logic        load_req = 1'b0;

  acc_t acc_q[$];
  acc_t exp_q[$];
  acc_t stall_q[$];
  int   done_q[$];

  int   gmode = 0;
  logic arm = 1'b1;
  logic rnd_bit = 1'b1;
  int   stall_left = 0;
  logic trig_rdf = 1'b0;
  logic trig_wrf = 1'b0;
  logic gnt_c;
  logic rdf_hit;
  logic wrf_hit;

  sand_sweep_if #(.ADDR_W(AW)) bus ();

  sand_sweep #(.WORDS_PER_ROW(W), .ROWS(R), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stub core
  assign bus.upd_new_region = ~bus.upd_region;
  assign bus.upd_new_floor  = bus.upd_floor + 32'd1;
  assign bus.mem_gnt        = gnt_c;

  // RAM: read data is garbage except the cycle after a granted read
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NW; i++) ram[i] <= img[i];
    end else if (bus.mem_req && bus.mem_gnt && int'(bus.mem_addr) < NW && bus.mem_we) begin
      ram[int'(bus.mem_addr)] <= bus.mem_wdata;
    end
    if (bus.mem_req && bus.mem_gnt && !bus.mem_we && int'(bus.mem_addr) < NW)
      bus.mem_rdata <= ram[int'(bus.mem_addr)];
    else
      bus.mem_rdata <= $urandom;
  end

  assign rdf_hit = bus.mem_req && !bus.mem_we && int'(bus.mem_addr) == W;
  assign wrf_hit = bus.mem_req &&  bus.mem_we && int'(bus.mem_addr) == W;

  always_comb begin
    gnt_c = 1'b1;
    if (gmode == 1) begin
      gnt_c = rnd_bit;
    end else if (gmode == 2) begin
      if (stall_left > 0)            gnt_c = 1'b0;
      else if (!trig_rdf && rdf_hit) gnt_c = 1'b0;
      else if (!trig_wrf && wrf_hit) gnt_c = 1'b0;
    end
  end

  always @(posedge clk) begin
    rnd_bit <= ($urandom_range(0, 3) != 0);
    if (arm) begin
      stall_left <= 0;
      trig_rdf   <= 1'b0;
      trig_wrf   <= 1'b0;
    end else if (gmode == 2) begin
      if (stall_left > 0) stall_left <= stall_left - 1;
      else if (!trig_rdf && rdf_hit) begin trig_rdf <= 1'b1; stall_left <= 6; end
      else if (!trig_wrf && wrf_hit) begin trig_wrf <= 1'b1; stall_left <= 6; end
    end
  end

  always @(negedge clk) begin
    if (reset_n && bus.mem_req && bus.mem_gnt)
      acc_q.push_back('{int'(bus.mem_addr), bus.mem_we, bus.mem_wdata,
                        bus.upd_screenbegin, bus.upd_screenend, bus.upd_region});
    if (gmode == 2 && reset_n && bus.mem_req && !bus.mem_gnt)
      stall_q.push_back('{int'(bus.mem_addr), bus.mem_we, bus.mem_wdata,
                          bus.upd_screenbegin, bus.upd_screenend, bus.upd_region});
    if (reset_n && done) done_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sweep model: every region row r pairs with floor row r+1, word by word.
  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_ram[i] = img[i];
    for (int r = 0; r < R - 1; r++) begin
      for (int w = 0; w < W; w++) begin
        int          ra;
        int          fa;
        logic [31:0] reg_v;
        logic [31:0] fl_v;
        bit          sb;
        bit          se;
        ra    = r * W + w;
        fa    = ra + W;
        reg_v = exp_ram[ra];
        fl_v  = exp_ram[fa];
        sb    = (w == 0);
        se    = (w == W - 1);
        exp_q.push_back('{ra, 1'b0, 32'h0, sb, se, 32'h0});
        exp_q.push_back('{fa, 1'b0, 32'h0, sb, se, 32'h0});
        exp_q.push_back('{ra, 1'b1, ~reg_v, sb, se, reg_v});
        exp_q.push_back('{fa, 1'b1, fl_v + 32'd1, sb, se, reg_v});
        exp_ram[ra] = ~reg_v;
        exp_ram[fa] = fl_v + 32'd1;
      end
    end
  endtask

  task automatic prep(input int mode);
    @(negedge clk);
    gmode    = mode;
    arm      = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    arm      = 1'b0;
    load_req = 1'b0;
    acc_q.delete();
    stall_q.delete();
    done_q.delete();
    build_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic pulse_start(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_q.size() != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_run(input string tag);
    chk({tag, "_nacc"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), acc_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_we%0d", tag, i), acc_q[i].we, exp_q[i].we);
      chk($sformatf("%s_sb%0d", tag, i), acc_q[i].sb, exp_q[i].sb);
      chk($sformatf("%s_se%0d", tag, i), acc_q[i].se, exp_q[i].se);
      if (exp_q[i].we) begin
        chk($sformatf("%s_wdata%0d", tag, i), acc_q[i].wdata, exp_q[i].wdata);
        chk($sformatf("%s_region%0d", tag, i), acc_q[i].region, exp_q[i].region);
      end
    end
    for (int i = 0; i < NW; i++)
      chk($sformatf("%s_ram%0d", tag, i), ram[i], exp_ram[i]);
    chk({tag, "_done_once"}, done_q.size(), 1);
    chk({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    int t0;
    for (int i = 0; i < NW; i++) img[i] = 32'(i);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, '0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_region", bus.upd_region, 32'h0);
    chk("rst_floor", bus.upd_floor, 32'h0);
    reset_n = 1'b1;

    // smoke sweep, grant always high
    prep(0);
    pulse_start(t0);
    wait_done("smoke", 200);
    chk("smoke_done_cyc", (done_q.size() > 0) ? done_q[0] - t0 : -1, 5 * NWORDS + 1);
    compare_run("smoke");

    // seven-cycle grant stalls in the first RD_F and the first WR_F
    do_reset();
    prep(2);
    pulse_start(t0);
    wait_done("stall", 300);
    chk("stall_done_cyc", (done_q.size() > 0) ? done_q[0] - t0 : -1, 5 * NWORDS + 1 + 14);
    chk("stall_n", stall_q.size(), 14);
    for (int i = 0; i < stall_q.size() && i < 14; i++) begin
      if (i < 7) begin
        chk($sformatf("stall_rdf_addr%0d", i), stall_q[i].addr, exp_q[1].addr);
        chk($sformatf("stall_rdf_we%0d", i), stall_q[i].we, 1'b0);
        if (i > 0) chk($sformatf("stall_rdf_region%0d", i), stall_q[i].region, img[0]);
      end else begin
        chk($sformatf("stall_wrf_addr%0d", i), stall_q[i].addr, exp_q[3].addr);
        chk($sformatf("stall_wrf_we%0d", i), stall_q[i].we, 1'b1);
        chk($sformatf("stall_wrf_wdata%0d", i), stall_q[i].wdata, exp_q[3].wdata);
      end
    end
    compare_run("stall");

    // start while busy ignored, start on the done cycle accepted
    do_reset();
    prep(0);
    pulse_start(t0);
    while (cyc < t0 + 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 21) @(negedge clk);
    chk("rej_done_at21", done, 1'b1);
    chk("rej_busy_at21", busy, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_restart_cyc", cyc - t0, 22);
    chk("rej_restart_req", bus.mem_req, 1'b1);
    chk("rej_restart_addr", bus.mem_addr, '0);
    chk("rej_restart_we", bus.mem_we, 1'b0);
    chk("rej_restart_busy", busy, 1'b1);
    chk("rej_done_once", done_q.size(), 1);

    // asynchronous reset during WR_R of word 2
    do_reset();
    prep(0);
    pulse_start(t0);
    while (cyc < t0 + 14) @(negedge clk);
    chk("mid_pre_we", bus.mem_we, 1'b1);
    chk("mid_pre_addr", bus.mem_addr, AW'(W));
    chk("mid_pre_region", bus.upd_region, img[W] + 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_req", bus.mem_req, 1'b0);
    chk("mid_we", bus.mem_we, 1'b0);
    chk("mid_addr", bus.mem_addr, '0);
    chk("mid_wdata", bus.mem_wdata, 32'h0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_region", bus.upd_region, 32'h0);
    chk("mid_floor", bus.upd_floor, 32'h0);
    acc_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_access", acc_q.size(), 0);
    chk("mid_no_done", done_q.size(), 0);
    chk("mid_idle_busy", busy, 1'b0);
    chk("mid_idle_req", bus.mem_req, 1'b0);

    // random contents with random grant
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int i = 0; i < NW; i++) img[i] = $urandom;
      prep(1);
      pulse_start(t0);
      wait_done($sformatf("rnd%0d", it), 2000);
      compare_run($sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
